// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX stage: control-word packing and ALUOp encodings.
package id_ex_stage_reg_pkg;

    // Width of the packed control word {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegDst,ALUOp[1:0],Branch}
    localparam int CTRL_W = 9;

    // Bit positions inside the control word
    typedef enum int unsigned {
        CTRL_BRANCH   = 0,
        CTRL_ALUOP_LO = 1,
        CTRL_ALUOP_HI = 2,
        CTRL_REGDST   = 3,
        CTRL_ALUSRC   = 4,
        CTRL_MEMTOREG = 5,
        CTRL_MEMWRITE = 6,
        CTRL_MEMREAD  = 7,
        CTRL_REGWRITE = 8
    } ctrl_bit_e;

    // ALUOp field encodings handed to the ALU control decoder in EX
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } alu_op_e;

    // True when the control word describes a memory load
    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination (rt) is read by the instruction in ID.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    output logic                  hazard_o
);

    logic rs_match;
    logic rt_match;

    // Register $0 is never a real producer, so a load to $0 cannot create a hazard
    always_comb begin
        rs_match = id_uses_rs_i && (id_rs_i == ex_rt_i);
        rt_match = id_uses_rt_i && (id_rt_i == ex_rt_i);
        hazard_o = ex_valid_i && ex_mem_read_i && id_valid_i && (ex_rt_i != '0)
                   && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall generation and a saturating stall counter.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IfIdValid,
    input  logic [REG_ADDR_W-1:0] IfIdRegRs,
    input  logic [REG_ADDR_W-1:0] IfIdRegRt,
    input  logic [REG_ADDR_W-1:0] IfIdRegRd,
    input  logic                  IfIdUsesRs,
    input  logic                  IfIdUsesRt,
    input  logic [DATA_W-1:0]     IdReadData1,
    input  logic [DATA_W-1:0]     IdReadData2,
    input  logic [DATA_W-1:0]     IdSignExtImm,
    input  logic [CTRL_W-1:0]     IdCtrl,
    input  logic                  Flush,
    output logic                  IdExValid,
    output logic [REG_ADDR_W-1:0] IdExRegRs,
    output logic [REG_ADDR_W-1:0] IdExRegRt,
    output logic [REG_ADDR_W-1:0] IdExRegRd,
    output logic [DATA_W-1:0]     IdExData1,
    output logic [DATA_W-1:0]     IdExData2,
    output logic [DATA_W-1:0]     IdExImm,
    output logic [CTRL_W-1:0]     IdExCtrl,
    output logic                  Stall,
    output logic [CNT_W-1:0]      StallCount
);

    logic                  valid_q,  valid_d;
    logic [REG_ADDR_W-1:0] rs_q,     rs_d;
    logic [REG_ADDR_W-1:0] rt_q,     rt_d;
    logic [REG_ADDR_W-1:0] rd_q,     rd_d;
    logic [DATA_W-1:0]     data1_q,  data1_d;
    logic [DATA_W-1:0]     data2_q,  data2_d;
    logic [DATA_W-1:0]     imm_q,    imm_d;
    logic [CTRL_W-1:0]     ctrl_q,   ctrl_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic                  hazard;
    logic                  bubble;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_is_load(ctrl_q)),
        .ex_rt_i       (rt_q),
        .id_valid_i    (IfIdValid),
        .id_rs_i       (IfIdRegRs),
        .id_rt_i       (IfIdRegRt),
        .id_uses_rs_i  (IfIdUsesRs),
        .id_uses_rt_i  (IfIdUsesRt),
        .hazard_o      (hazard)
    );

    // A redirect discards the dependent instruction, so it suppresses the stall
    assign Stall  = hazard && !Flush;
    assign bubble = Flush || hazard || !IfIdValid;

    // Next-state: zeroed bubble by default, ID fields only when the slot is real; counter saturates
    always_comb begin
        valid_d = 1'b0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        data1_d = '0;
        data2_d = '0;
        imm_d   = '0;
        ctrl_d  = '0;
        if (!bubble) begin
            valid_d = 1'b1;
            rs_d    = IfIdRegRs;
            rt_d    = IfIdRegRt;
            rd_d    = IfIdRegRd;
            data1_d = IdReadData1;
            data2_d = IdReadData2;
            imm_d   = IdSignExtImm;
            ctrl_d  = IdCtrl;
        end
        cnt_d = cnt_q;
        if (Stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline register and stall counter with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IdExValid  = valid_q;
    assign IdExRegRs  = rs_q;
    assign IdExRegRt  = rt_q;
    assign IdExRegRd  = rd_q;
    assign IdExData1  = data1_q;
    assign IdExData2  = data2_q;
    assign IdExImm    = imm_q;
    assign IdExCtrl   = ctrl_q;
    assign StallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: driver pushes expected EX state, monitor pops and compares.
module tb_id_ex_stage_reg;

    localparam logic [8:0] CTRL_LW  = 9'h1B0;
    localparam logic [8:0] CTRL_ADD = 9'h10C;

    typedef struct {
        bit        v;
        bit [4:0]  rs, rt, rd;
        bit [31:0] d1, d2, imm;
        bit [8:0]  ctrl;
    } ex_t;

    typedef struct {
        bit        v;
        bit [4:0]  rs, rt, rd;
        bit        urs, urt;
        bit [31:0] d1, d2, imm;
        bit [8:0]  ctrl;
    } inst_t;

    typedef struct {
        ex_t ex;
        int  cnt;
        int  cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        IfIdValid, IfIdUsesRs, IfIdUsesRt, Flush;
    logic [4:0]  IfIdRegRs, IfIdRegRt, IfIdRegRd;
    logic [31:0] IdReadData1, IdReadData2, IdSignExtImm;
    logic [8:0]  IdCtrl;

    logic        IdExValid, Stall;
    logic [4:0]  IdExRegRs, IdExRegRt, IdExRegRd;
    logic [31:0] IdExData1, IdExData2, IdExImm;
    logic [8:0]  IdExCtrl;
    logic [15:0] StallCount;

    logic        v2, stall2;
    logic [4:0]  rs2, rt2, rd2;
    logic [31:0] da2, db2, im2;
    logic [8:0]  ct2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    exp_t  sb[$];
    ex_t   m_ex;
    int    m_cnt, m_cnt2;
    bit    known = 0;
    bit    last_stall = 0;
    int    stall_seen = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .IfIdValid(IfIdValid),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdRegRd(IfIdRegRd),
        .IfIdUsesRs(IfIdUsesRs), .IfIdUsesRt(IfIdUsesRt),
        .IdReadData1(IdReadData1), .IdReadData2(IdReadData2), .IdSignExtImm(IdSignExtImm),
        .IdCtrl(IdCtrl), .Flush(Flush),
        .IdExValid(IdExValid), .IdExRegRs(IdExRegRs), .IdExRegRt(IdExRegRt), .IdExRegRd(IdExRegRd),
        .IdExData1(IdExData1), .IdExData2(IdExData2), .IdExImm(IdExImm), .IdExCtrl(IdExCtrl),
        .Stall(Stall), .StallCount(StallCount)
    );

    id_ex_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .IfIdValid(IfIdValid),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdRegRd(IfIdRegRd),
        .IfIdUsesRs(IfIdUsesRs), .IfIdUsesRt(IfIdUsesRt),
        .IdReadData1(IdReadData1), .IdReadData2(IdReadData2), .IdSignExtImm(IdSignExtImm),
        .IdCtrl(IdCtrl), .Flush(Flush),
        .IdExValid(v2), .IdExRegRs(rs2), .IdExRegRt(rt2), .IdExRegRd(rd2),
        .IdExData1(da2), .IdExData2(db2), .IdExImm(im2), .IdExCtrl(ct2),
        .Stall(stall2), .StallCount(cnt2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Load-use rule stated directly: EX holds a valid load to a non-zero rt that ID reads
    function automatic bit model_hazard(input ex_t ex, input inst_t id);
        if (!(ex.v && ex.ctrl[7] && id.v)) return 0;
        if (ex.rt == 5'd0) return 0;
        return (id.urs && id.rs == ex.rt) || (id.urt && id.rt == ex.rt);
    endfunction

    function automatic inst_t rand_inst();
        inst_t t;
        t.v    = ($urandom_range(0, 9) != 0);
        t.rs   = 5'($urandom_range(0, 3));
        t.rt   = 5'($urandom_range(0, 3));
        t.rd   = 5'($urandom);
        t.urs  = 1'($urandom);
        t.urt  = 1'($urandom);
        t.d1   = $urandom;
        t.d2   = $urandom;
        t.imm  = $urandom;
        t.ctrl = 9'($urandom);
        return t;
    endfunction

    function automatic inst_t mk(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                                 input bit urs, input bit urt, input bit [8:0] ctrl);
        inst_t t;
        t.v = 1; t.rs = rs; t.rt = rt; t.rd = rd; t.urs = urs; t.urt = urt;
        t.d1 = $urandom; t.d2 = $urandom; t.imm = $urandom; t.ctrl = ctrl;
        return t;
    endfunction

    task automatic step(input inst_t in, input bit fl, input bit r);
        bit hz, es;
        exp_t e;
        @(negedge clk);
        rst = r; Flush = fl;
        IfIdValid = in.v; IfIdRegRs = in.rs; IfIdRegRt = in.rt; IfIdRegRd = in.rd;
        IfIdUsesRs = in.urs; IfIdUsesRt = in.urt;
        IdReadData1 = in.d1; IdReadData2 = in.d2; IdSignExtImm = in.imm; IdCtrl = in.ctrl;
        #1;
        hz = model_hazard(m_ex, in);
        es = hz && !fl;
        if (known) chk("stall", 128'(Stall), 128'(es));
        if (es) stall_seen++;
        if (r) begin
            m_ex = '{default: 0};
            m_cnt = 0; m_cnt2 = 0;
            known = 1;
        end else begin
            if (es) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (fl || hz || !in.v) m_ex = '{default: 0};
            else begin
                m_ex.v = 1; m_ex.rs = in.rs; m_ex.rt = in.rt; m_ex.rd = in.rd;
                m_ex.d1 = in.d1; m_ex.d2 = in.d2; m_ex.imm = in.imm; m_ex.ctrl = in.ctrl;
            end
        end
        e.ex = m_ex; e.cnt = m_cnt; e.cnt2 = m_cnt2;
        sb.push_back(e);
        last_stall = es;
    endtask

    task automatic load_use(input bit [4:0] r);
        inst_t dep;
        step(mk(5'd1, r, 5'd0, 1, 0, CTRL_LW), 0, 0);
        dep = mk(r, 5'd4, 5'd3, 1, 1, CTRL_ADD);
        step(dep, 0, 0);
        step(dep, 0, 0);
    endtask

    // Monitor: compare the registered outputs against the oldest expectation after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid", 128'(IdExValid), 128'(e.ex.v));
                chk("ctrl",  128'(IdExCtrl),  128'(e.ex.ctrl));
                chk("regs",  128'({IdExRegRs, IdExRegRt, IdExRegRd}), 128'({e.ex.rs, e.ex.rt, e.ex.rd}));
                chk("data",  {32'd0, IdExData1, IdExData2, IdExImm}, {32'd0, e.ex.d1, e.ex.d2, e.ex.imm});
                chk("cnt",   128'(StallCount), 128'(e.cnt));
                chk("cnt_sat", 128'(cnt2), 128'(e.cnt2));
            end
        end
    end

    initial begin
        inst_t cur;
        int s0;
        rst = 1; Flush = 0; IfIdValid = 0; IfIdRegRs = 0; IfIdRegRt = 0; IfIdRegRd = 0;
        IfIdUsesRs = 0; IfIdUsesRt = 0; IdReadData1 = 0; IdReadData2 = 0; IdSignExtImm = 0; IdCtrl = 0;

        // Reset for two cycles with random inputs
        step(rand_inst(), 1'($urandom), 1);
        step(rand_inst(), 1'($urandom), 1);

        // lw $2 ; add $3,$2,$4
        s0 = stall_seen;
        load_use(5'd2);
        chk("lu_stalls", 128'(stall_seen - s0), 128'(1));

        // No stall: load to $0, and rt match without UsesRt
        s0 = stall_seen;
        step(mk(5'd1, 5'd0, 5'd0, 1, 0, CTRL_LW), 0, 0);
        step(mk(5'd0, 5'd0, 5'd3, 1, 1, CTRL_ADD), 0, 0);
        step(mk(5'd1, 5'd2, 5'd0, 1, 0, CTRL_LW), 0, 0);
        step(mk(5'd5, 5'd2, 5'd3, 1, 0, CTRL_ADD), 0, 0);
        chk("no_stall", 128'(stall_seen - s0), 128'(0));

        // Hazard together with Flush
        s0 = stall_seen;
        step(mk(5'd1, 5'd6, 5'd0, 1, 0, CTRL_LW), 0, 0);
        step(mk(5'd6, 5'd4, 5'd3, 1, 1, CTRL_ADD), 1, 0);
        chk("flush_stall", 128'(stall_seen - s0), 128'(0));

        // Saturation of the 2-bit counter after reset and five load-use sequences
        step(rand_inst(), 0, 1);
        for (int i = 0; i < 5; i++) load_use(5'(i + 1));
        @(negedge clk);
        chk("sat_cnt2", 128'(cnt2), 128'(3));
        chk("cnt5", 128'(StallCount), 128'(5));

        // Four independent ALU ops back to back
        s0 = stall_seen;
        for (int i = 0; i < 4; i++) step(mk(5'(8 + i), 5'(12 + i), 5'(16 + i), 1, 1, CTRL_ADD), 0, 0);
        chk("stream_stalls", 128'(stall_seen - s0), 128'(0));

        // Random pipeline-like traffic: IF/ID holds its instruction while stalled
        cur = rand_inst();
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) cur = rand_inst();
            step(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
